// File: rtl/timer_peripheral_pkg.sv
// Shared data-bus encodings plus the timer register map.
// Also imported by the core's data bus control unit and by future bus peripherals.
package timer_peripheral_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'b00,
        BUS_READ  = 2'b01,
        BUS_WRITE = 2'b10,
        BUS_RSVD  = 2'b11
    } bus_mode_e;

    typedef enum logic [1:0] {
        REQW_BYTE  = 2'b00,
        REQW_HALF  = 2'b01,
        REQW_WORD  = 2'b10,
        REQW_WORD2 = 2'b11
    } bus_reqw_e;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_ONE_SHOT    = 2;
    localparam int CTRL_IRQ_EN      = 3;

    // Replace only the byte lanes flagged in wr_strb.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wr_data,
                                                input logic [3:0]  wr_strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_peripheral_data_bus_responder.sv
// Generic data-bus responder: window decode, write lane steering, two-cycle
// read capture and the tri-state read driver.
module data_bus_responder
    import timer_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic [1:0]  data_bus_reqw,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] reg_rdata,
    output logic [2:0]  reg_offset,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb
);

    bus_mode_e   mode;
    bus_reqw_e   reqw;
    logic        sel;
    logic        rd_sel;
    logic        rd_valid;
    logic [31:0] rd_q;

    assign mode       = bus_mode_e'(data_bus_mode);
    assign reqw       = bus_reqw_e'(data_bus_reqw);
    assign sel        = (data_bus_addr[31:5] == BASE_ADDR[31:5]) &&
                        (mode == BUS_READ || mode == BUS_WRITE);
    assign rd_sel     = sel && (mode == BUS_READ);
    assign wr_en      = sel && (mode == BUS_WRITE);
    assign reg_offset = data_bus_addr[4:2];

    // Replicating the low-order data across lanes places it in every lane the strobe can pick.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        wr_strb = 4'b1111;
        wr_data = data_bus_data;
        case (reqw)
            REQW_BYTE: begin
                wr_strb = 4'b0001 << data_bus_addr[1:0];
                wr_data = {4{data_bus_data[7:0]}};
            end
            REQW_HALF: begin
                wr_strb = data_bus_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_bus_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Capture only on the first stall cycle so a COUNT read returns that cycle's value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rd_q     <= '0;
            rd_valid <= 1'b0;
        end else if (rd_sel) begin
            if (!rd_valid) rd_q <= reg_rdata;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    assign data_bus_data = (rd_sel && rd_valid) ? rd_q : 'z;

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped compare timer with prescaler, auto-reload / one-shot modes and
// an active-low level interrupt cleared by a write-1 to STATUS.
module timer_peripheral
    import timer_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic [1:0]  data_bus_reqw,
    input  logic        data_bus_reqs,
    inout  wire  [31:0] data_bus_data,
    output logic        irq_n
);

    logic [3:0]  ctrl;
    logic [31:0] prescale;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic [31:0] pre_cnt;

    logic [2:0]  reg_offset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] reg_rdata;
    logic [31:0] ctrl_word;

    logic ctrl_wr, prescale_wr, count_wr, compare_wr, status_wr;
    logic tick, hit, status_clr;
    logic unused_reqs;

    // Sign extension happens in the core, so the signed-load flag is not needed here.
    assign unused_reqs = data_bus_reqs;

    data_bus_responder #(.BASE_ADDR(BASE_ADDR)) u_responder (
        .clk           (clk),
        .reset         (reset),
        .data_bus_addr (data_bus_addr),
        .data_bus_mode (data_bus_mode),
        .data_bus_reqw (data_bus_reqw),
        .data_bus_data (data_bus_data),
        .reg_rdata     (reg_rdata),
        .reg_offset    (reg_offset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb)
    );

    always_comb begin
        reg_rdata = '0;
        case (reg_offset)
            OFF_CTRL:     reg_rdata = {28'b0, ctrl};
            OFF_PRESCALE: reg_rdata = prescale;
            OFF_COUNT:    reg_rdata = count;
            OFF_COMPARE:  reg_rdata = compare;
            OFF_STATUS:   reg_rdata = {31'b0, match};
            default:      reg_rdata = '0;
        endcase
    end

    assign ctrl_wr     = wr_en && (reg_offset == OFF_CTRL);
    assign prescale_wr = wr_en && (reg_offset == OFF_PRESCALE);
    assign count_wr    = wr_en && (reg_offset == OFF_COUNT);
    assign compare_wr  = wr_en && (reg_offset == OFF_COMPARE);
    assign status_wr   = wr_en && (reg_offset == OFF_STATUS);
    assign status_clr  = status_wr && wr_strb[0] && wr_data[0];
    assign ctrl_word   = merge_lanes({28'b0, ctrl}, wr_data, wr_strb);

    assign tick = ctrl[CTRL_EN] && (pre_cnt == prescale);
    assign hit  = tick && (count == compare);

    // Software writes take priority over timer updates; MATCH uses the pre-write COUNT.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= '0;
            count    <= '0;
            compare  <= '0;
            match    <= 1'b0;
            pre_cnt  <= '0;
            irq_n    <= 1'b1;
        end else begin
            if (prescale_wr)         pre_cnt <= '0;
            else if (ctrl[CTRL_EN])  pre_cnt <= tick ? '0 : pre_cnt + 32'd1;

            if (prescale_wr) prescale <= merge_lanes(prescale, wr_data, wr_strb);
            if (compare_wr)  compare  <= merge_lanes(compare, wr_data, wr_strb);

            if (count_wr)  count <= merge_lanes(count, wr_data, wr_strb);
            else if (tick) count <= (hit && ctrl[CTRL_AUTO_RELOAD]) ? '0 : count + 32'd1;

            if (ctrl_wr)                         ctrl          <= ctrl_word[3:0];
            else if (hit && ctrl[CTRL_ONE_SHOT]) ctrl[CTRL_EN] <= 1'b0;

            if (hit)             match <= 1'b1;
            else if (status_clr) match <= 1'b0;

            irq_n <= ~(match & ctrl[CTRL_IRQ_EN]);
        end
    end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral: bus accesses driven on the falling edge,
// expected values computed by hand from the register behaviour.
module tb_timer_peripheral;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
    localparam logic [31:0] A_COUNT    = BASE + 32'h08;
    localparam logic [31:0] A_COMPARE  = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS   = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic [1:0]  data_bus_reqw;
    logic        data_bus_reqs;
    wire  [31:0] data_bus_data;
    logic        irq_n;
    logic        tb_oe;
    logic [31:0] tb_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    assign data_bus_data = tb_oe ? tb_wdata : 'z;

    always #5 clk = ~clk;

    timer_peripheral #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_bus_addr (data_bus_addr),
        .data_bus_mode (data_bus_mode),
        .data_bus_reqw (data_bus_reqw),
        .data_bus_reqs (data_bus_reqs),
        .data_bus_data (data_bus_data),
        .irq_n         (irq_n)
    );

    // Called on a falling edge; the store commits at the next rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] reqw);
        data_bus_addr = addr;
        data_bus_mode = 2'b10;
        data_bus_reqw = reqw;
        tb_wdata      = data;
        tb_oe         = 1'b1;
        @(negedge clk);
        data_bus_mode = 2'b00;
        tb_oe         = 1'b0;
    endtask

    // Two-cycle load: capture at the first edge, sample in the second cycle, then one idle cycle.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        data_bus_addr = addr;
        data_bus_mode = 2'b01;
        data_bus_reqw = 2'b10;
        @(negedge clk);
        data = data_bus_data;
        @(negedge clk);
        data_bus_mode = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        for (int i = 0; i < 8; i++) begin
            bus_read(BASE + 32'(i * 4), got);
            n_cmp++;
            if (got !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_read_off%0h got=%h want=%h", i * 4, got, 32'h0);
            end
        end
        n_cmp++;
        if (irq_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_irq_n got=%b want=1", irq_n);
        end
    endtask

    task automatic check_bus_idle(input string name);
        n_cmp++;
        if (!(data_bus_data === {32{1'bz}} || data_bus_data === 32'h0)) begin
            n_bad++;
            $display("FAIL %s bus driven while idle got=%h want=high-Z", name, data_bus_data);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] got;
        bus_write(A_COMPARE, 32'h1122_3344, 2'b10);
        bus_write(A_COMPARE + 32'd2, 32'h0000_00AB, 2'b00);
        bus_read(A_COMPARE, got);
        n_cmp++;
        if (got !== 32'h11AB_3344) begin
            n_bad++;
            $display("FAIL byte_store got=%h want=%h", got, 32'h11AB_3344);
        end
        check_bus_idle("idle_after_read");
        bus_write(A_COMPARE + 32'd2, 32'h0000_BEEF, 2'b01);
        bus_read(A_COMPARE, got);
        n_cmp++;
        if (got !== 32'hBEEF_3344) begin
            n_bad++;
            $display("FAIL half_store got=%h want=%h", got, 32'hBEEF_3344);
        end
        bus_write(32'h0002_000C, 32'hDEAD_0000, 2'b10);
        bus_read(A_COMPARE, got);
        n_cmp++;
        if (got !== 32'hBEEF_3344) begin
            n_bad++;
            $display("FAIL out_of_window_write got=%h want=%h", got, 32'hBEEF_3344);
        end
        bus_write(BASE + 32'h14, 32'hFFFF_FFFF, 2'b10);
        bus_read(BASE + 32'h14, got);
        n_cmp++;
        if (got !== 32'h0) begin
            n_bad++;
            $display("FAIL unused_offset got=%h want=%h", got, 32'h0);
        end
        // reqw 11 behaves as a word store and ignores addr[1:0]
        bus_write(A_CTRL + 32'd1, 32'hFFFF_FF08, 2'b11);
        bus_read(A_CTRL, got);
        n_cmp++;
        if (got !== 32'h0000_0008) begin
            n_bad++;
            $display("FAIL ctrl_unused_bits got=%h want=%h", got, 32'h8);
        end
    endtask

    task automatic test_prescale_autoreload();
        logic [31:0] got;
        bus_write(A_PRESCALE, 32'd2, 2'b10);
        bus_write(A_COMPARE, 32'd3, 2'b10);
        bus_write(A_CTRL, 32'hB, 2'b10);
        repeat (12) @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_early got=%b want=1", irq_n);
        end
        @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_after_match got=%b want=0", irq_n);
        end
        bus_read(A_COUNT, got);
        n_cmp++;
        if (got !== 32'h0) begin
            n_bad++;
            $display("FAIL count_after_reload got=%h want=%h", got, 32'h0);
        end
        bus_write(A_CTRL, 32'h8, 2'b10);
        bus_read(A_STATUS, got);
        n_cmp++;
        if (got !== 32'h1) begin
            n_bad++;
            $display("FAIL status_match got=%h want=%h", got, 32'h1);
        end
        bus_write(A_STATUS, 32'h1, 2'b10);
        n_cmp++;
        if (irq_n !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_rise_early got=%b want=0", irq_n);
        end
        @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_after_clear got=%b want=1", irq_n);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] got;
        bus_write(A_COUNT, 32'h0, 2'b10);
        bus_write(A_COMPARE, 32'h0, 2'b10);
        bus_write(A_PRESCALE, 32'h0, 2'b10);
        bus_write(A_STATUS, 32'h1, 2'b10);
        bus_write(A_CTRL, 32'h5, 2'b10);
        @(negedge clk);
        bus_read(A_CTRL, got);
        n_cmp++;
        if (got !== 32'h4) begin
            n_bad++;
            $display("FAIL one_shot_ctrl got=%h want=%h", got, 32'h4);
        end
        bus_read(A_COUNT, got);
        n_cmp++;
        if (got !== 32'h1) begin
            n_bad++;
            $display("FAIL one_shot_count got=%h want=%h", got, 32'h1);
        end
        bus_read(A_STATUS, got);
        n_cmp++;
        if (got !== 32'h1) begin
            n_bad++;
            $display("FAIL one_shot_match got=%h want=%h", got, 32'h1);
        end
        n_cmp++;
        if (irq_n !== 1'b1) begin
            n_bad++;
            $display("FAIL one_shot_irq_masked got=%b want=1", irq_n);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        bus_write(A_STATUS, 32'h1, 2'b10);
        bus_write(A_PRESCALE, 32'h0, 2'b10);
        bus_write(A_COMPARE, 32'd5, 2'b10);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 2'b10);
        bus_write(A_CTRL, 32'h9, 2'b10);
        repeat (7) @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_irq_early got=%b want=1", irq_n);
        end
        @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_irq got=%b want=0", irq_n);
        end
        // Nine ticks since enable: 0xFFFF_FFFF + 9 wraps to 8.
        bus_write(A_CTRL, 32'h8, 2'b10);
        bus_read(A_COUNT, got);
        n_cmp++;
        if (got !== 32'd8) begin
            n_bad++;
            $display("FAIL wrap_count got=%h want=%h", got, 32'd8);
        end
    endtask

    task automatic test_status_collision();
        logic [31:0] got;
        bus_write(A_STATUS, 32'h1, 2'b10);
        bus_write(A_PRESCALE, 32'h0, 2'b10);
        bus_write(A_COMPARE, 32'h0, 2'b10);
        bus_write(A_COUNT, 32'h0, 2'b10);
        bus_write(A_CTRL, 32'hB, 2'b10);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b0) begin
            n_bad++;
            $display("FAIL collision_irq_before got=%b want=0", irq_n);
        end
        bus_write(A_STATUS, 32'h1, 2'b10);
        @(negedge clk);
        n_cmp++;
        if (irq_n !== 1'b0) begin
            n_bad++;
            $display("FAIL collision_irq_after got=%b want=0", irq_n);
        end
        bus_read(A_STATUS, got);
        n_cmp++;
        if (got !== 32'h1) begin
            n_bad++;
            $display("FAIL collision_match got=%h want=%h", got, 32'h1);
        end
        bus_read(A_COUNT, got);
        n_cmp++;
        if (got !== 32'h0) begin
            n_bad++;
            $display("FAIL collision_count got=%h want=%h", got, 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        data_bus_addr = '0;
        data_bus_mode = 2'b00;
        data_bus_reqw = 2'b10;
        data_bus_reqs = 1'b0;
        tb_oe         = 1'b0;
        tb_wdata      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        test_reset();
        test_byte_lanes();
        test_prescale_autoreload();
        test_one_shot();
        test_wrap();
        test_status_collision();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_peripheral.md
# timer_peripheral

Memory-mapped timer that sits on the core's data bus as a responder and returns its interrupt on one active-low line of `irq_sources`. Software programs a prescaler, compare value and control bits through word/half/byte stores, and reads back the count and status through loads. The load response follows the core's two-cycle load stall. A compare match raises a level interrupt that stays asserted until software clears it.

## Interface
- `BASE_ADDR`, default 32'h0001_0000: 32-byte-aligned base of the register window.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `reset` input 1: synchronous, active-high.
- `data_bus_addr` input 32: byte address from the core.
- `data_bus_mode` input 2: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- `data_bus_reqw` input 2: access width; 00 byte, 01 half, 10 word, 11 treated as word.
- `data_bus_reqs` input 1: signed-load request; ignored (sign extension is performed in the core).
- `data_bus_data` inout 32: driven only while a read selects this block; high-Z otherwise.
- `irq_n` output 1: active-low interrupt, wired to one `irq_sources` bit.

## Operation
- Select `sel` = (`data_bus_addr[31:5]` == `BASE_ADDR[31:5]`) and mode is 01 or 10. Offset is `addr[4:2]`.
- Register map:
  - 0x00 CTRL[3:0]: bit0 EN, bit1 AUTO_RELOAD, bit2 ONE_SHOT, bit3 IRQ_EN.
  - 0x04 PRESCALE[31:0].
  - 0x08 COUNT[31:0].
  - 0x0C COMPARE[31:0].
  - 0x10 STATUS, bit0 MATCH, write-1-to-clear.
  - Offsets 0x14 to 0x1C read as 0; writes to them are ignored.
  - Unused CTRL and STATUS bits read as 0.
- Writes:
  - Write data arrives in the low-order bits and is shifted into the lane given by `addr[1:0]`. Byte uses lane `addr[1:0]`; half uses lane pair `addr[1]`; word ignores `addr[1:0]`.
  - Unselected bytes are preserved.
  - A write commits at the edge where mode == 10 and `sel` is true.
- Reads:
  - The full 32-bit register word is returned regardless of `reqw`. The core extracts and extends the addressed lanes.
- Prescaler:
  - While EN = 1, internal `pre_cnt` increments each cycle.
  - When `pre_cnt` == PRESCALE, a tick occurs and `pre_cnt` returns to 0.
  - PRESCALE = 0 therefore gives a tick every cycle.
  - While EN = 0, `pre_cnt` holds.
- On each tick:
  - If COUNT == COMPARE: MATCH is set to 1. COUNT becomes 0 if AUTO_RELOAD = 1, otherwise COUNT+1. If ONE_SHOT = 1, EN is cleared.
  - Otherwise, COUNT becomes COUNT+1.
  - COUNT arithmetic is modulo 2^32 (0xFFFF_FFFF + 1 = 0).
- Interrupt: `irq_n` = ~(MATCH & IRQ_EN), registered.
- Collision rules (same edge):
  - A software write to COUNT overrides the tick's update of COUNT. MATCH is still evaluated from the pre-write COUNT.
  - A write to PRESCALE also clears `pre_cnt`.
  - STATUS write-1-to-clear together with a new match leaves MATCH = 1; set wins.
  - A CTRL write together with a one-shot clear of EN: the software value wins.

## Timing
- Reset values: all registers 0, `pre_cnt` 0, `irq_n` 1, `data_bus_data` high-Z. Reset asserted mid-access aborts the access with no write committed.
- Read response:
  - Cycle 1 (first cycle of the load stall): at the edge with `sel` and mode 01, the addressed register is captured into `rd_q` and `rd_valid` is set.
  - Cycle 2: `data_bus_data` = `rd_q` while `sel`, mode 01 and `rd_valid` are all true. The core samples the data in this cycle.
  - `rd_valid` clears once mode leaves 01 or `sel` drops.
  - COUNT reads return the cycle-1 value.
- Interrupt latency: `irq_n` falls one cycle after the tick edge that sets MATCH. It rises one cycle after MATCH or IRQ_EN clears.
- Write latency: a written value is visible to a read issued in the next cycle.
- There is no back-pressure. Every selected access completes within the core's fixed timing.

## Structure
- Shared package/header holds:
  - The bus mode encodings and `reqw` encodings, also used by the core's data bus control unit.
  - The register offsets and CTRL bit indices.
- Sub-module `data_bus_responder`: address decode, lane merge for writes, the read-capture register and the tri-state driver. It is reusable by the future GPIO and UART peripherals.

## Test plan
- Reset, then read every offset: all return 0; `irq_n` = 1; the bus is high-Z when not selected.
- PRESCALE = 2, COMPARE = 3, CTRL = 0b1011 (EN, AUTO_RELOAD, IRQ_EN):
  - MATCH sets after 12 enabled cycles (COUNT passes 0, 1, 2, 3).
  - `irq_n` falls one cycle later.
  - COUNT reads back 0 after the reload.
- ONE_SHOT with COMPARE = 0, PRESCALE = 0: EN reads 0 two cycles after enable, and COUNT stays at 1.
- COUNT = 0xFFFF_FFFF, COMPARE = 5, PRESCALE = 0, EN = 1: COUNT wraps to 0 and MATCH sets on the sixth tick after the wrap.
- Byte store of 0xAB to COMPARE+2 over 0x1122_3344: the readback is 0x11AB_3344.
- STATUS write of 1 on the same edge as a new match: MATCH remains 1 and `irq_n` stays low.
